// File: rtl/v_line_mux.sv
// v_line_mux: Wishbone-configured selector steering one macro's east/west pad buses onto a
// vertical line, with output blanking on switchover. Optional output pipeline: V_LINE_MUX_PIPE_EN.
module v_line_mux #(
    parameter int          NUM_MACROS   = 3,
    parameter int          EW_W         = 14,
    parameter int          BLANK_CYCLES = 4,
    parameter logic [31:0] CFG_ADDR     = 32'h3000_0000
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [NUM_MACROS*EW_W-1:0] west_o_in,
    input  logic [NUM_MACROS*EW_W-1:0] west_oe_in,
    input  logic [NUM_MACROS*EW_W-1:0] east_o_in,
    input  logic [NUM_MACROS*EW_W-1:0] east_oe_in,
    output logic [EW_W-1:0]            west_o_sel,
    output logic [EW_W-1:0]            west_oe_sel,
    output logic [EW_W-1:0]            east_o_sel,
    output logic [EW_W-1:0]            east_oe_sel,
    output logic [((NUM_MACROS > 2) ? $clog2(NUM_MACROS) : 1)-1:0] active_sel,
    output logic                       switching
);
    localparam int         SEL_W      = (NUM_MACROS > 2) ? $clog2(NUM_MACROS) : 1;
    localparam logic [7:0] NUM_M8     = 8'(NUM_MACROS);
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

    typedef enum logic {S_IDLE, S_BLANK} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_active_sel, w_active_nxt;
    logic [7:0]         r_req_sel, r_req_last;
    logic               r_ack;
    logic [31:0]        r_dat;
    logic               w_req, w_hit, w_wr_ok, w_switching;
    logic [31:0]        w_cfg_rd;
    logic [EW_W-1:0]    w_west_o, w_west_oe, w_east_o, w_east_oe;
    logic               w_unused;

    assign w_unused    = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:8]};
    assign w_switching = (r_state == S_BLANK);
    assign w_req       = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_hit       = (wbs_adr_i == CFG_ADDR);
    assign w_wr_ok     = w_req & wbs_we_i & w_hit & wbs_sel_i[0] & (wbs_dat_i[7:0] < NUM_M8);
    assign w_cfg_rd    = {15'b0, w_switching, 8'(r_active_sel), r_req_sel};

    // Ack is blocked for one cycle after an ack so each strobe yields a single pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_req_sel  <= '0;
            r_req_last <= '0;
        end else begin
            r_ack      <= w_req;
            r_dat      <= (w_req && !wbs_we_i && w_hit) ? w_cfg_rd : 32'h0;
            r_req_last <= r_req_sel;
            if (w_wr_ok)
                r_req_sel <= wbs_dat_i[7:0];
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_active_sel <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_active_sel <= w_active_nxt;
        end
    end

    // A request change seen while blanking restarts the full blank window.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active_sel;
        case (r_state)
            S_IDLE: begin
                if (r_req_sel != 8'(r_active_sel)) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = BLANK_LOAD;
                end
            end
            S_BLANK: begin
                if (r_req_sel != r_req_last) begin
                    w_cnt_nxt = BLANK_LOAD;
                end else if (r_cnt == 8'd0) begin
                    w_active_nxt = r_req_sel[SEL_W-1:0];
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    function automatic logic [EW_W-1:0] pick(input logic [NUM_MACROS*EW_W-1:0] bus,
                                             input logic [SEL_W-1:0] idx);
        pick = '0;
        for (int k = 0; k < NUM_MACROS; k++)
            if (idx == SEL_W'(k))
                pick = bus[k*EW_W +: EW_W];
    endfunction

    always_comb begin
        w_west_o  = '0;
        w_west_oe = '0;
        w_east_o  = '0;
        w_east_oe = '0;
        if (!w_switching) begin
            w_west_o  = pick(west_o_in,  r_active_sel);
            w_west_oe = pick(west_oe_in, r_active_sel);
            w_east_o  = pick(east_o_in,  r_active_sel);
            w_east_oe = pick(east_oe_in, r_active_sel);
        end
    end

`ifdef V_LINE_MUX_PIPE_EN
    logic [EW_W-1:0]  r_west_o, r_west_oe, r_east_o, r_east_oe;
    logic [SEL_W-1:0] r_active_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_west_o   <= '0;
            r_west_oe  <= '0;
            r_east_o   <= '0;
            r_east_oe  <= '0;
            r_active_q <= '0;
        end else begin
            r_west_o   <= w_west_o;
            r_west_oe  <= w_west_oe;
            r_east_o   <= w_east_o;
            r_east_oe  <= w_east_oe;
            r_active_q <= r_active_sel;
        end
    end

    assign west_o_sel  = r_west_o;
    assign west_oe_sel = r_west_oe;
    assign east_o_sel  = r_east_o;
    assign east_oe_sel = r_east_oe;
    assign active_sel  = r_active_q;
`else
    // Gated by reset so the pads never see a macro while the block is held in reset.
    assign west_o_sel  = wb_rst_n_i ? w_west_o  : '0;
    assign west_oe_sel = wb_rst_n_i ? w_west_oe : '0;
    assign east_o_sel  = wb_rst_n_i ? w_east_o  : '0;
    assign east_oe_sel = wb_rst_n_i ? w_east_oe : '0;
    assign active_sel  = r_active_sel;
`endif

    assign switching = w_switching;

endmodule

// File: tb/tb_v_line_mux.sv
// Bench for v_line_mux: directed scenarios plus random Wishbone/bus traffic checked against a
// timeline model (blank ends BLANK_CYCLES after the last request change).
module tb_v_line_mux;
    localparam int          NM = 3;
    localparam int          EW = 14;
    localparam int          B  = 4;
    localparam logic [31:0] CA = 32'h3000_0000;
    localparam int          SW = (NM > 2) ? $clog2(NM) : 1;
`ifdef V_LINE_MUX_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_n_i;
    logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [NM*EW-1:0]  bus_in [4];
    logic [EW-1:0]     west_o_sel, west_oe_sel, east_o_sel, east_oe_sel;
    logic [EW-1:0]     sel_out [4];
    logic [SW-1:0]     active_sel;
    logic              switching;

    v_line_mux #(.NUM_MACROS(NM), .EW_W(EW), .BLANK_CYCLES(B), .CFG_ADDR(CA)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .west_o_in(bus_in[0]), .west_oe_in(bus_in[1]),
        .east_o_in(bus_in[2]), .east_oe_in(bus_in[3]),
        .west_o_sel(west_o_sel), .west_oe_sel(west_oe_sel),
        .east_o_sel(east_o_sel), .east_oe_sel(east_oe_sel),
        .active_sel(active_sel), .switching(switching)
    );

    assign sel_out[0] = west_o_sel;
    assign sel_out[1] = west_oe_sel;
    assign sel_out[2] = east_o_sel;
    assign sel_out[3] = east_oe_sel;

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: request/active values, blank window (m_start, m_end] in cycle indices.
    int              n_cyc;
    int              m_req, m_active, m_start, m_end;
    logic            m_ack;
    logic [31:0]     m_rdat;
    logic [EW-1:0]   e_prev [4];
    int              e_prev_act;
    string           out_name [4] = '{"west_o_sel", "west_oe_sel", "east_o_sel", "east_oe_sel"};

    function automatic bit blank_at(input int n);
        return (n > m_start) && (n <= m_end);
    endfunction

    function automatic logic [EW-1:0] exp_comb(input logic [NM*EW-1:0] bus, input bit blk,
                                               input int act);
        if (blk) return '0;
        return bus[act*EW +: EW];
    endfunction

    task automatic model_reset();
        m_req = 0; m_active = 0; m_start = n_cyc; m_end = n_cyc;
        m_ack = 1'b0; m_rdat = '0; e_prev_act = 0;
        for (int i = 0; i < 4; i++) e_prev[i] = '0;
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        chk("ack", wbs_ack_o, m_ack);
        chk("dat_o", wbs_dat_o, m_rdat);
        chk("switching", switching, wb_rst_n_i && blank_at(n_cyc));
        for (int i = 0; i < 4; i++) begin
            if (PIPE) e = e_prev[i];
            else      e = wb_rst_n_i ? exp_comb(bus_in[i], blank_at(n_cyc), m_active) : '0;
            chk(out_name[i], sel_out[i], e);
        end
        chk("active_sel", active_sel, PIPE ? e_prev_act : m_active);
    endtask

    task automatic tick();
        logic acc;
        bit   blk_old;
        int   req_old;
        for (int i = 0; i < 4; i++)
            e_prev[i] = wb_rst_n_i ? exp_comb(bus_in[i], blank_at(n_cyc), m_active) : '0;
        e_prev_act = wb_rst_n_i ? m_active : 0;
        blk_old    = blank_at(n_cyc);
        acc        = wbs_stb_i & wbs_cyc_i & ~m_ack;
        @(posedge wb_clk_i);
        n_cyc++;
        if (!wb_rst_n_i) begin
            model_reset();
        end else begin
            m_rdat = (acc && !wbs_we_i && wbs_adr_i == CA) ?
                     {15'b0, blk_old, 8'(m_active), 8'(m_req)} : 32'h0;
            m_ack  = acc;
            if (n_cyc == m_end + 1) m_active = m_req;
            req_old = m_req;
            if (acc && wbs_we_i && wbs_adr_i == CA && wbs_sel_i[0] && wbs_dat_i[7:0] < NM)
                m_req = int'(wbs_dat_i[7:0]);
            if (m_req != req_old && (blank_at(n_cyc) || m_req != m_active)) begin
                if (!blank_at(n_cyc)) m_start = n_cyc;
                m_end = n_cyc + B;
            end
        end
        @(negedge wb_clk_i);
        check_outputs();
    endtask

    task automatic rand_bus();
        logic [63:0] r64;
        for (int i = 0; i < 4; i++) begin
            r64 = {$urandom(), $urandom()};
            bus_in[i] = r64[NM*EW-1:0];
        end
    endtask

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit keep, output logic [31:0] rd);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        tick();
        rd = wbs_dat_o;
        if (keep) tick();
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        tick();
    endtask

    task automatic do_reset(input int n);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        #2 wb_rst_n_i = 1'b0;
        #1 model_reset();
        check_outputs();
        repeat (n) tick();
        wb_rst_n_i = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt;
        bit          saw1;
        wb_rst_n_i = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        for (int i = 0; i < 4; i++) bus_in[i] = '0;
        n_cyc = 0;
        model_reset();
        bus_in[0][EW-1:0] = 14'h1ABC;
        #1 check_outputs();
        repeat (2) tick();
        wb_rst_n_i = 1'b1;

        // Power-up: macro 0 drives the pads with no configuration.
        repeat (2) tick();
        chk("pwrup_west_1abc", west_o_sel, 32'h1ABC);
        chk("pwrup_active", active_sel, 0);
        chk("pwrup_switching", switching, 0);

        // Plain 0->1 switch: blank length and new source.
        rand_bus();
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = CA; wbs_dat_i = 32'h1; wbs_sel_i = 4'h1;
        tick();
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        cnt = 0;
        repeat (12) begin
            tick();
            if (switching) cnt++;
        end
        chk("blank_len", cnt, B);
        chk("switch_active1", active_sel, 1);

        // Retarget during blank: macro 1 must never appear.
        do_reset(2);
        rand_bus();
        wb(1'b1, CA, 32'h1, 4'h1, 1'b0, rd);
        wb(1'b1, CA, 32'h2, 4'h1, 1'b0, rd);
        saw1 = 1'b0;
        repeat (14) begin
            tick();
            if (active_sel == SW'(1)) saw1 = 1'b1;
        end
        chk("never_macro1", saw1, 0);
        chk("retarget_active2", active_sel, 2);

        // Illegal select, reads during blank, reset mid-blank.
        do_reset(2);
        wb(1'b1, CA, 32'h3, 4'h1, 1'b0, rd);
        wb(1'b0, CA, 32'h0, 4'h0, 1'b0, rd);
        chk("rd_after_illegal", rd, 32'h0);
        wb(1'b1, CA, 32'h1, 4'h1, 1'b0, rd);
        wb(1'b0, CA, 32'h0, 4'h0, 1'b0, rd);
        chk("rd_in_blank", rd, 32'h0001_0001);
        do_reset(1);
        chk("rst_abort_switching", switching, 0);
        repeat (8) tick();
        chk("rst_abort_active", active_sel, 0);
        wb(1'b0, CA + 32'd4, 32'h0, 4'h0, 1'b0, rd);
        chk("rd_other_addr", rd, 32'h0);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            rand_bus();
            if (r < 4)
                wb(1'b1, CA, ($urandom() & 32'hFFFF_FF00) | $urandom_range(0, NM), 4'h1,
                   1'($urandom_range(0, 1)), rd);
            else if (r == 4)
                wb(1'b1, CA, $urandom_range(0, NM - 1), 4'hE, 1'b0, rd);
            else if (r == 5)
                wb(1'b1, CA + 32'd4, $urandom_range(0, NM - 1), 4'hF, 1'b0, rd);
            else if (r == 6)
                wb(1'b0, CA, 32'h0, 4'hF, 1'($urandom_range(0, 1)), rd);
            else if (r == 7)
                wb(1'b0, $urandom() | 32'h1, 32'h0, 4'hF, 1'b0, rd);
            else
                repeat ($urandom_range(1, 6)) begin
                    tick();
                    rand_bus();
                end
            if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 2));
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
